cbrt_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one cbrt core among N_REQ requesters.

---
 rtl/cbrt_rr_sched.sv | 169 ++++++++++++++++
 tb/tb_cbrt_rr_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbrt_rr_sched.sv
// Round-robin scheduler that shares one cbrt core among N_REQ requesters.
// Optional one-entry result cache: define CBRT_SCHED_CACHE_EN to enable it.
module cbrt_rr_sched #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*IN_W-1:0]   req_a_bi,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [OUT_W-1:0]        y_bo,
    output logic                    busy_o,
    output logic                    cbrt_start_o,
    output logic [IN_W-1:0]         cbrt_a_bo,
    input  logic [1:0]              cbrt_busy_i,
    input  logic [OUT_W-1:0]        cbrt_y_bi
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_nextPtr;
    logic [IDX_W:0]     w_scan;
    logic               w_found;
    logic [IN_W-1:0]    r_operand;
    logic [IN_W-1:0]    w_winOperand;
    logic [OUT_W-1:0]   r_y;
    logic [OUT_W-1:0]   w_hitY;
    logic [1:0]         r_waitCnt;
    logic               w_coreBusy;
    logic               w_cacheHit;

    assign w_coreBusy   = |cbrt_busy_i;
    assign w_winOperand = req_a_bi[w_winner*IN_W +: IN_W];
    assign w_nextPtr    = (w_winner == IDX_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;

    // Scan requests starting at the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_scan >= (IDX_W+1)'(N_REQ)) begin
                w_scan = w_scan - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && req_i[w_scan[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[IDX_W-1:0];
            end
        end
    end

`ifdef CBRT_SCHED_CACHE_EN
    logic               r_cacheValid;
    logic [IN_W-1:0]    r_cacheA;
    logic [OUT_W-1:0]   r_cacheY;

    assign w_cacheHit = r_cacheValid && (w_winOperand == r_cacheA);
    assign w_hitY     = r_cacheY;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cacheValid <= 1'b0;
            r_cacheA     <= '0;
            r_cacheY     <= '0;
        end else if (r_state == CAPTURE) begin
            r_cacheValid <= 1'b1;
            r_cacheA     <= r_operand;
            r_cacheY     <= r_y;
        end
    end
`else
    assign w_cacheHit = 1'b0;
    assign w_hitY     = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant is suppressed while reset is asserted so every output reads 0.
    always_comb begin
        w_nextState  = r_state;
        grant_o      = '0;
        done_o       = '0;
        cbrt_start_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !rst_i) begin
                    grant_o[w_winner] = 1'b1;
                    w_nextState       = w_cacheHit ? CAPTURE : START;
                end
            end
            START: begin
                cbrt_start_o = 1'b1;
                w_nextState  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (w_coreBusy) begin
                    w_nextState = WAIT_DONE;
                end else if (r_waitCnt == 2'd3) begin
                    w_nextState = CAPTURE;
                end
            end
            WAIT_DONE: begin
                if (!w_coreBusy) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                done_o[r_owner] = 1'b1;
                w_nextState     = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The result is latched on entry to CAPTURE so it is valid alongside done_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_operand <= '0;
            r_y       <= '0;
            r_waitCnt <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_ptr     <= w_nextPtr;
                r_owner   <= w_winner;
                r_operand <= w_winOperand;
            end
            if (r_state == START) begin
                r_waitCnt <= '0;
            end else if (r_state == WAIT_BUSY) begin
                r_waitCnt <= r_waitCnt + 2'd1;
            end
            if (r_state != CAPTURE && w_nextState == CAPTURE) begin
                r_y <= (r_state == IDLE) ? w_hitY : cbrt_y_bi;
            end
        end
    end

    assign busy_o    = (r_state != IDLE);
    assign y_bo      = r_y;
    assign cbrt_a_bo = r_operand;

endmodule

// File: tb/tb_cbrt_rr_sched.sv
// Directed self-checking bench for cbrt_rr_sched with a behavioural cbrt core.
// Build with CBRT_SCHED_CACHE_EN defined to exercise the result cache path.
module tb_cbrt_rr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int OW = 4;

`ifdef CBRT_SCHED_CACHE_EN
    localparam int HIT_LAT    = 1;
    localparam int HIT_STARTS = 0;
`else
    localparam int HIT_LAT    = 7;
    localparam int HIT_STARTS = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   reqA;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [OW-1:0]    y;
    logic             busy;
    logic             coreStart;
    logic [W-1:0]     coreAIn;
    logic [1:0]       coreBusy;
    logic [OW-1:0]    coreY;
    logic [W-1:0]     coreA;
    int               coreCnt;
    logic             degenerate;

    int vectors        = 0;
    int miscompares    = 0;
    int cycleNo        = 0;
    int grantCount     = 0;
    int doneCount      = 0;
    int startCount     = 0;
    int lastGrantCycle = 0;

    cbrt_rr_sched #(.N_REQ(N), .IN_W(W), .OUT_W(OW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_a_bi     (reqA),
        .grant_o      (grant),
        .done_o       (done),
        .y_bo         (y),
        .busy_o       (busy),
        .cbrt_start_o (coreStart),
        .cbrt_a_bo    (coreAIn),
        .cbrt_busy_i  (coreBusy),
        .cbrt_y_bi    (coreY)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] cubeRoot(input logic [W-1:0] a);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(a)) r++;
        return OW'(r);
    endfunction

    // Behavioural core: busy for four cycles after start, or never busy in degenerate mode.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            coreBusy <= 2'b00;
            coreCnt  <= 0;
            coreY    <= '0;
            coreA    <= '0;
        end else if (coreStart) begin
            coreA <= coreAIn;
            if (degenerate) begin
                coreY <= cubeRoot(coreAIn);
            end else begin
                coreBusy <= 2'b10;
                coreCnt  <= 3;
            end
        end else if (coreBusy != 2'b00) begin
            if (coreCnt == 0) begin
                coreBusy <= 2'b00;
                coreY    <= cubeRoot(coreA);
            end else begin
                coreCnt <= coreCnt - 1;
            end
        end
    end

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Pulse bookkeeping sampled on the falling edge.
    always @(negedge clk) begin
        if (grant != '0) begin
            grantCount     <= grantCount + 1;
            lastGrantCycle <= cycleNo;
        end
        if (done != '0) doneCount <= doneCount + 1;
        if (coreStart) startCount <= startCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] a);
        @(posedge clk);
        #1;
        req  = r;
        reqA = a;
    endtask

    task automatic waitGrant(output logic [N-1:0] g);
        bit seen = 1'b0;
        g = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g    = grant;
                seen = 1'b1;
            end
        end
    endtask

    task automatic waitDone(output logic [N-1:0] d, output logic [OW-1:0] yy, output int cyc);
        bit seen = 1'b0;
        d   = '0;
        yy  = '0;
        cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done != '0) begin
                d    = done;
                yy   = y;
                cyc  = cycleNo;
                seen = 1'b1;
            end
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One complete job: request, drop after grant, wait for done, confirm return to idle.
    task automatic serve(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] a,
                         input logic [N-1:0] expG, input logic [OW-1:0] expY,
                         input int expLat, input int expStarts);
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic [OW-1:0] yy;
        int            cyc;
        int            base;
        base = startCount;
        applyStimulus(r, a);
        waitGrant(g);
        checkOutput({tag, ".grant"}, 32'(g), 32'(expG));
        applyStimulus(r & ~g, a);
        waitDone(d, yy, cyc);
        checkOutput({tag, ".done"}, 32'(d), 32'(expG));
        checkOutput({tag, ".y"}, 32'(yy), 32'(expY));
        checkOutput({tag, ".latency"}, 32'(cyc - lastGrantCycle), 32'(expLat));
        checkOutput({tag, ".starts"}, 32'(startCount - base), 32'(expStarts));
        @(negedge clk);
        checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0]   g;
        logic [N-1:0]   d;
        logic [N-1:0]   reqVec;
        logic [OW-1:0]  yy;
        logic [W-1:0]   expY2 [4];
        logic [W-1:0]   expY3 [4];
        logic [N-1:0]   expG3 [4];
        int             cyc;
        int             base;

        expY2 = '{8'd2, 8'd3, 8'd4, 8'd5};
        expY3 = '{8'd2, 8'd1, 8'd2, 8'd1};
        expG3 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

        rst        = 1'b1;
        req        = 4'b1111;
        reqA       = {8'd10, 8'd20, 8'd30, 8'd40};
        degenerate = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.grant", 32'(grant), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.y", 32'(y), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.start", 32'(coreStart), 32'd0);
        checkOutput("reset.a", 32'(coreAIn), 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single requester, a=200");
        serve("single", 4'b0001, {24'd0, 8'd200}, 4'b0001, 4'd5, 7, 1);
        checkOutput("single.aHeld", 32'(coreAIn), 32'd200);

        $display("[TB] four simultaneous requests from reset");
        doReset();
        reqVec = 4'b1111;
        applyStimulus(reqVec, {8'd125, 8'd68, 8'd28, 8'd8});
        for (int k = 0; k < 4; k++) begin
            waitGrant(g);
            checkOutput("all4.grant", 32'(g), 32'(1 << k));
            reqVec = reqVec & ~g;
            applyStimulus(reqVec, {8'd125, 8'd68, 8'd28, 8'd8});
            waitDone(d, yy, cyc);
            checkOutput("all4.done", 32'(d), 32'(1 << k));
            checkOutput("all4.y", 32'(yy), 32'(expY2[k]));
        end

        $display("[TB] requesters 0 and 2 held high");
        base = grantCount;
        applyStimulus(4'b0101, {8'd0, 8'd2, 8'd0, 8'd9});
        for (int k = 0; k < 4; k++) begin
            waitGrant(g);
            checkOutput("alt.grant", 32'(g), 32'(expG3[k]));
            waitDone(d, yy, cyc);
            checkOutput("alt.done", 32'(d), 32'(expG3[k]));
            checkOutput("alt.y", 32'(yy), 32'(expY3[k]));
        end
        req = '0;
        repeat (5) @(negedge clk);
        checkOutput("alt.grantCount", 32'(grantCount - base), 32'd4);
        checkOutput("alt.idle", 32'(busy), 32'd0);

        $display("[TB] reset during WAIT_DONE");
        applyStimulus(4'b0001, {24'd0, 8'd255});
        waitGrant(g);
        checkOutput("rstJob.grant", 32'(g), 32'b0001);
        applyStimulus(4'b0000, {24'd0, 8'd255});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstJob.busyBefore", 32'(busy), 32'd1);
        base = doneCount;
        rst  = 1'b1;
        #1;
        checkOutput("rstJob.busy", 32'(busy), 32'd0);
        checkOutput("rstJob.y", 32'(y), 32'd0);
        checkOutput("rstJob.done", 32'(done), 32'd0);
        checkOutput("rstJob.start", 32'(coreStart), 32'd0);
        checkOutput("rstJob.a", 32'(coreAIn), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rstJob.noDone", 32'(doneCount - base), 32'd0);
        serve("afterRst", 4'b0001, {24'd0, 8'd1}, 4'b0001, 4'd1, 7, 1);

        $display("[TB] degenerate core never raises busy");
        @(posedge clk);
        #1;
        degenerate = 1'b1;
        serve("degen", 4'b0010, {16'd0, 8'd64, 8'd0}, 4'b0010, 4'd4, 6, 1);
        degenerate = 1'b0;

        $display("[TB] same operand twice back-to-back");
        serve("repeat1", 4'b0001, {24'd0, 8'd255}, 4'b0001, 4'd6, 7, 1);
        serve("repeat2", 4'b0001, {24'd0, 8'd255}, 4'b0001, 4'd6, HIT_LAT, HIT_STARTS);

        $display("[TB] operand zero with other slices busy");
        serve("zero", 4'b0100, {8'd27, 8'd0, 8'd125, 8'd216}, 4'b0100, 4'd0, 7, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
